// File: rtl/regfile_bank.sv
// Parametrised register file: byte-enable writes, optional same-cycle write bypass,
// and a clear sequencer that zeroes every entry after reset while holding Busy.
module regfile_bank #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREGS),
  localparam int NB = XLEN / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic [AW-1:0]         WriteAddr,
  input  logic [XLEN-1:0]       WriteData,
  input  logic [NB-1:0]         WriteBE,
  input  logic [NREAD*AW-1:0]   ReadAddr,
  output logic [NREAD*XLEN-1:0] ReadData,
  output logic                  Busy,
  output logic                  WriteErr
);

  // state | meaning
  // CLEAR | zeroing entry clear_idx_q on each edge; reads return 0, writes rejected
  // RUN   | normal read/write operation
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clear_idx_q, clear_idx_d;
  logic              werr_q, werr_d;
  logic              clr_en;
  logic              wr_en;
  logic [XLEN-1:0]   wr_merged;
  logic [XLEN-1:0]   mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clear_idx_q <= '0;
      werr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      werr_q      <= werr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    werr_d      = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_idx_d = clear_idx_q + AW'(1);
        werr_d      = RegWrite;
        if (clear_idx_q == AW'(NREGS - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    Busy     = (state_q == CLEAR);
    WriteErr = werr_q;
    clr_en   = (state_q == CLEAR);
    wr_en    = RegWrite && (state_q == RUN) &&
               !((ZERO_REG != 0) && (WriteAddr == '0));
  end

  // Byte merge shared by the storage write and the bypass path.
  always_comb begin
    wr_merged = mem_q[WriteAddr];
    for (int b = 0; b < NB; b++) begin
      if (WriteBE[b]) wr_merged[8*b +: 8] = WriteData[8*b +: 8];
    end
  end

  // Storage has no reset of its own; the clear sequence is what initialises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en)     mem_q[clear_idx_q] <= '0;
      else if (wr_en) mem_q[WriteAddr]   <= wr_merged;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_word;

    assign rd_addr = ReadAddr[k*AW +: AW];

    always_comb begin
      rd_word = mem_q[rd_addr];
      if (Busy)
        rd_word = '0;
      else if ((ZERO_REG != 0) && (rd_addr == '0))
        rd_word = '0;
      else if ((BYPASS != 0) && wr_en && (rd_addr == WriteAddr))
        rd_word = wr_merged;
    end

    assign ReadData[k*XLEN +: XLEN] = rd_word;
  end

endmodule
